// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared constants and helpers for the scoreboarded register file.
//   DEF_ADDR_W / DEF_DATA_W / DEF_NUM_RD : default geometry of the integer register file
//   ZERO_ADDR                            : address of the hardwired zero register
//   slice_field()                        : extracts field idx of width w from a flattened vector
package reg_file_sb_pkg;

  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_RD  = 2;
  localparam int ZERO_ADDR   = 0;

  // Widest flattened vector / field the helper handles (4 ports x 64 bits).
  localparam int MAX_VEC_W   = 256;
  localparam int MAX_FIELD_W = 64;

  // Returns vec[idx*w +: w], zero-extended to MAX_FIELD_W bits.
  function automatic logic [MAX_FIELD_W-1:0] slice_field(
    input logic [MAX_VEC_W-1:0] vec,
    input int                   idx,
    input int                   w
  );
    logic [MAX_VEC_W-1:0]   shifted;
    logic [MAX_FIELD_W-1:0] mask;
    shifted = vec >> (idx * w);
    if (w >= MAX_FIELD_W) begin
      mask = '1;
    end else begin
      mask = (64'd1 << w) - 64'd1;
    end
    return shifted[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/reg_sb_scoreboard.sv
// reg_sb_scoreboard: per-register pending bits plus an incrementally maintained count.
//   clk, reset      : clock, synchronous active-high clear
//   pend_set/addr   : decode allocates a writer for pend_addr (sets the bit)
//   wr_en/wr_addr   : writeback retires the writer of wr_addr (clears the bit)
//   flush           : clears every pending bit, overriding set and clear
//   pend_q          : pending bit vector, one bit per register
//   pend_cnt        : number of set bits in pend_q
module reg_sb_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pend_set,
  input  logic [ADDR_W-1:0]      pend_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   flush,
  output logic [(2**ADDR_W)-1:0] pend_q,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int N = 2 ** ADDR_W;

  logic [N-1:0]    pend_d;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_d;
  logic            set_ok_s;
  logic            clr_ok_s;
  logic            inc_s;
  logic            dec_s;

  assign pend_cnt = cnt_q;

  // Next pending vector and count; set beats clear on the same address.
  always_comb begin
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    set_ok_s = pend_set && !((ZERO_REG != 0) && (pend_addr == ADDR_W'(ZERO_ADDR)));
    clr_ok_s = wr_en    && !((ZERO_REG != 0) && (wr_addr   == ADDR_W'(ZERO_ADDR)));
    // A 0->1 edge only when the target is idle; a 1->0 edge only when the
    // cleared register is pending and not being re-allocated this cycle.
    inc_s    = set_ok_s && !pend_q[pend_addr];
    dec_s    = clr_ok_s && pend_q[wr_addr] && !(set_ok_s && (pend_addr == wr_addr));
    if (flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (clr_ok_s) begin
        pend_d[wr_addr] = 1'b0;
      end else begin
        pend_d = pend_d;
      end
      if (set_ok_s) begin
        pend_d[pend_addr] = 1'b1;
      end else begin
        pend_d = pend_d;
      end
      case ({inc_s, dec_s})
        2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pending state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: N-read / 1-write integer register file with built-in scoreboard.
//   clk, reset          : clock, synchronous active-high clear of storage and scoreboard
//   rd_addr / rd_data   : flattened read ports, port k at [k*W +: W]; reads are combinational
//   rd_rdy              : port k operand valid (no pending writer)
//   wr_en/addr/data     : writeback port, lands at posedge
//   pend_set/pend_addr  : decode allocates a writer
//   flush               : clears all pending bits (storage write still happens)
//   pend_cnt            : number of pending registers
// Optional macro REG_FILE_SB_BYPASS_EN: same-cycle forwarding of writeback data to reads.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_rdy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int N = 2 ** ADDR_W;

  logic [N-1:0][DATA_W-1:0] mem_q;
  logic [N-1:0][DATA_W-1:0] mem_d;
  logic [N-1:0]             pend_s;
  logic [MAX_VEC_W-1:0]     rd_addr_ext_s;
  logic                     wr_ok_s;
  logic [ADDR_W-1:0]        rd_a_s;

  assign rd_addr_ext_s = MAX_VEC_W'(rd_addr);
  assign wr_ok_s       = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR)));

  reg_sb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .flush     (flush),
    .pend_q    (pend_s),
    .pend_cnt  (pend_cnt)
  );

  // Storage next state; writes to x0 are dropped, flush does not block the write.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok_s) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes and ready flags per port.
  always_comb begin
    rd_data = '0;
    rd_rdy  = '0;
    rd_a_s  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_a_s = ADDR_W'(slice_field(rd_addr_ext_s, k, ADDR_W));
      if ((ZERO_REG != 0) && (rd_a_s == ADDR_W'(ZERO_ADDR))) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_rdy[k]                   = 1'b1;
`ifdef REG_FILE_SB_BYPASS_EN
      end else if (wr_ok_s && (wr_addr == rd_a_s)) begin
        // Forwarded operand is valid now even if decode re-allocates it this cycle.
        rd_data[k*DATA_W +: DATA_W] = wr_data;
        rd_rdy[k]                   = 1'b1;
`endif
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem_q[rd_a_s];
        rd_rdy[k]                   = ~pend_s[rd_a_s];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: table-driven self-checking bench for reg_file_sb (default 2 read ports).
// Each row is one cycle of stimulus plus the outputs expected during that cycle
// (i.e. the state left by earlier rows). Expected records go through a queue.
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_rdy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic        flush;
  logic [5:0]  pend_cnt;

  reg_file_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_rdy    (rd_rdy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .flush     (flush),
    .pend_cnt  (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ps;
    logic [4:0]  pa;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        chk;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erdy;
    logic [5:0]  ecnt;
  } vec_t;

  typedef struct {
    int          row;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erdy;
    logic [5:0]  ecnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(
    input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic ps, input logic [4:0] pa, input logic fl,
    input logic [4:0] r0, input logic [4:0] r1, input logic chk,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] erdy, input logic [5:0] ecnt
  );
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ps = ps; v.pa = pa; v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.chk = chk; v.e0 = e0; v.e1 = e1; v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0; flush = 1'b0;

    // Reset held two cycles while other inputs are active: reset must dominate.
    vecs.push_back(mk(1'b1, 1'b1, 5'd5, 32'hFF, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b11, 6'd0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd5, 32'hFF, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b11, 6'd0));
    // Read every address on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'(i), 5'(31 - i), 1'b1, 32'h0, 32'h0, 2'b11, 6'd0));
    end
    // Write x5, then x0 (discarded).
    vecs.push_back(mk(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b1, 32'h0, 32'h0, 2'b11, 6'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0, 2'b11, 6'd0));
    // Allocate x7 (x0 still reads 0).
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0, 2'b11, 6'd0));
    // Writeback x7 while reading it: bypass-dependent.
    vecs.push_back(mk(1'b0, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 1'b1,
                      BYP ? 32'h55 : 32'h0, 32'hDEADBEEF, BYP ? 2'b11 : 2'b10, 6'd1));
    // Same-cycle allocate and writeback of x3: new allocation wins, data still written.
    vecs.push_back(mk(1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 1'b0, 5'd7, 5'd3, 1'b1,
                      32'h55, BYP ? 32'hAA : 32'h0, 2'b11, 6'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd7, 1'b1, 32'hAA, 32'h55, 2'b10, 6'd1));
    // Allocate x9 while retiring pending x4: count unchanged.
    vecs.push_back(mk(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 1'b0, 5'd4, 5'd9, 1'b1,
                      BYP ? 32'h44 : 32'h0, 32'h0, BYP ? 2'b11 : 2'b10, 6'd2));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd4, 5'd9, 1'b1, 32'h44, 32'h0, 2'b01, 6'd2));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd3, 5'd3, 1'b1, 32'hAA, 32'hAA, 2'b00, 6'd3));
    // pend_set to x0 is ignored.
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd1, 5'd2, 1'b1, 32'h0, 32'h0, 2'b00, 6'd4));
    // Flush with a writeback and an allocation in the same cycle.
    vecs.push_back(mk(1'b0, 1'b1, 5'd8, 32'h10, 1'b1, 5'd5, 1'b1, 5'd9, 5'd0, 1'b1, 32'h0, 32'h0, 2'b10, 6'd4));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd5, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 6'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd3, 1'b1, 32'h0, 32'hAA, 2'b11, 6'd0));
    // x6: old value 0x66, pending, then writeback 0x77 while port 1 reads it.
    vecs.push_back(mk(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 2'b11, 6'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd3, 5'd9, 1'b1, 32'hAA, 32'h0, 2'b11, 6'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 1'b0, 5'd8, 5'd6, 1'b1,
                      32'h10, BYP ? 32'h77 : 32'h66, BYP ? 2'b11 : 2'b01, 6'd1));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd6, 1'b1, 32'h77, 32'h77, 2'b11, 6'd0));
    // Double allocation of x12 counts once.
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd0, 1'b1, 32'h0, 32'h0, 2'b11, 6'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd12, 1'b1, 32'h0, 32'h0, 2'b00, 6'd1));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd0, 1'b1, 32'h0, 32'h0, 2'b10, 6'd1));
    // Mid-operation reset with in-flight write and allocation: all discarded.
    vecs.push_back(mk(1'b1, 1'b1, 5'd11, 32'hBB, 1'b1, 5'd10, 1'b0, 5'd6, 5'd10, 1'b1, 32'h77, 32'h0, 2'b11, 6'd1));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd11, 1'b1, 32'h0, 32'h0, 2'b11, 6'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd12, 1'b1, 32'h0, 32'h0, 2'b11, 6'd0));

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      reset     = vecs[r].rst;
      wr_en     = vecs[r].we;
      wr_addr   = vecs[r].wa;
      wr_data   = vecs[r].wd;
      pend_set  = vecs[r].ps;
      pend_addr = vecs[r].pa;
      flush     = vecs[r].fl;
      rd_addr   = {vecs[r].r1, vecs[r].r0};
      if (vecs[r].chk) begin
        e.row = r; e.e0 = vecs[r].e0; e.e1 = vecs[r].e1; e.erdy = vecs[r].erdy; e.ecnt = vecs[r].ecnt;
        sb_q.push_back(e);
      end
      @(negedge clk);
      if (vecs[r].chk) begin
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty row=%0d actual=0 required=1", r);
        end else begin
          e = sb_q.pop_front();
          check("rd_data0", e.row, rd_data[31:0],  e.e0);
          check("rd_data1", e.row, rd_data[63:32], e.e1);
          check("rd_rdy",   e.row, {30'd0, rd_rdy}, {30'd0, e.erdy});
          check("pend_cnt", e.row, {26'd0, pend_cnt}, {26'd0, e.ecnt});
        end
      end
    end

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
